// File: rtl/mem_access_ctrl_if.sv
// Request/acknowledge bus between the MEM-stage sequencer and the data memory.
// The sequencer drives the request side; the memory drives the completion side.
interface mem_access_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer: issues one request per aligned access, stalls the pipeline
// until completion or timeout, and records the first misaligned/timed-out address.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    memread_m_i,
    input  logic                    memwrite_m_i,
    input  logic [31:0]             addr_m_i,
    input  logic [31:0]             wdata_m_i,
    input  logic                    err_clr_i,
    mem_access_ctrl_if.master       mem,
    output logic                    stall_m_o,
    output logic                    bubble_w_o,
    output logic [31:0]             rdata_w_o,
    output logic                    err_o,
    output logic [31:0]             err_addr_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e             state_q, state_d;
    logic               req_q, req_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;
    logic [31:0]        err_addr_q, err_addr_d;
    logic               tmo_q, tmo_d;

    logic               mem_op_s;
    logic               access_s;
    logic               misal_s;
    logic               stall_s;
    logic               bubble_s;
    logic               new_err_s;
    logic [31:0]        new_err_addr_s;

    assign mem_op_s = memread_m_i | memwrite_m_i;
    assign access_s = mem_op_s & (addr_m_i[1:0] == 2'b00);
    assign misal_s  = mem_op_s & (addr_m_i[1:0] != 2'b00);

    // Next-state, request capture, wait counter and error bookkeeping.
    always_comb begin
        state_d        = state_q;
        req_d          = req_q;
        we_d           = we_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        cnt_d          = cnt_q;
        rdata_d        = rdata_q;
        tmo_d          = tmo_q;
        stall_s        = 1'b0;
        bubble_s       = 1'b0;
        new_err_s      = 1'b0;
        new_err_addr_s = addr_q;

        case (state_q)
            S_IDLE: begin
                if (access_s) begin
                    stall_s  = 1'b1;
                    bubble_s = 1'b1;
                    state_d  = S_REQ;
                    req_d    = 1'b1;
                    we_d     = memwrite_m_i;
                    addr_d   = {addr_m_i[31:2], 2'b00};
                    wdata_d  = wdata_m_i;
                    cnt_d    = {CNT_W{1'b0}};
                    tmo_d    = 1'b0;
                end else if (misal_s) begin
                    bubble_s       = 1'b1;
                    new_err_s      = 1'b1;
                    new_err_addr_s = addr_m_i;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                stall_s  = 1'b1;
                bubble_s = 1'b1;
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = cnt_q;
                end
                // An ack arriving in the last allowed cycle still completes normally.
                if (mem.mem_ack) begin
                    req_d   = 1'b0;
                    state_d = S_DONE;
                    if (!we_q) begin
                        rdata_d = mem.mem_rdata;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    req_d          = 1'b0;
                    rdata_d        = 32'h0000_0000;
                    tmo_d          = 1'b1;
                    new_err_s      = 1'b1;
                    new_err_addr_s = addr_q;
                    state_d        = S_DONE;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_DONE: begin
                bubble_s = tmo_q & ~we_q;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // Sticky error: a new error beats a coincident clear and then records its address.
    always_comb begin
        if (new_err_s) begin
            err_d = 1'b1;
            if (!err_q || err_clr_i) begin
                err_addr_d = new_err_addr_s;
            end else begin
                err_addr_d = err_addr_q;
            end
        end else if (err_clr_i) begin
            err_d      = 1'b0;
            err_addr_d = err_addr_q;
        end else begin
            err_d      = err_q;
            err_addr_d = err_addr_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'h0000_0000;
            wdata_q    <= 32'h0000_0000;
            cnt_q      <= {CNT_W{1'b0}};
            rdata_q    <= 32'h0000_0000;
            err_q      <= 1'b0;
            err_addr_q <= 32'h0000_0000;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
            tmo_q      <= tmo_d;
        end
    end

    // Stall/bubble are decoded from state; reset forces them low even with an access pending.
    assign stall_m_o     = stall_s & rst_n;
    assign bubble_w_o    = bubble_s & rst_n;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign rdata_w_o     = rdata_q;
    assign err_o         = err_q;
    assign err_addr_o    = err_addr_q;

endmodule
